// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_pkg : fetch state encoding, opcode and address constants        |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package mips_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_e;

  localparam logic [5:0] C_OP_J    = 6'b000010;
  localparam logic [5:0] C_OP_JAL  = 6'b000011;
  localparam logic [5:0] C_OP_BEQ  = 6'b000100;
  localparam logic [5:0] C_OP_BNE  = 6'b000101;
  localparam logic [5:0] C_OP_BLEZ = 6'b000110;

  localparam logic [31:0] C_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] C_INT_VECTOR = 32'h0000_0080;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit_if : instruction-memory req/ack bus                       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);
endinterface
`default_nettype wire

// File: rtl/fetch_unit_next_pc_sel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | next_pc_sel : combinational next-PC priority select                  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module next_pc_sel
  import mips_pkg::*;
(
  input  logic        branch_i,
  input  logic        branch_eq_i,
  input  logic        branch_leq_i,
  input  logic        jump_i,
  input  logic        jump_reg_i,
  input  logic        exce_ret_i,
  input  logic        cond_eq_i,
  input  logic        cond_leq_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus4_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] epc_i,
  output logic [31:0] next_pc_o
);

  logic [31:0] w_br_off;
  logic        w_taken;

  always_comb begin
    w_br_off = {{14{instr_i[15]}}, instr_i[15:0], 2'b00};
    // Neither eq nor leq selected means bne.
    w_taken  = branch_i & ((branch_leq_i & cond_leq_i) |
                           (branch_eq_i & cond_eq_i) |
                           (~branch_eq_i & ~branch_leq_i & ~cond_eq_i));
    if (exce_ret_i)      next_pc_o = epc_i;
    else if (jump_reg_i) next_pc_o = rs_data_i;
    else if (jump_i)     next_pc_o = {pc_plus4_i[31:28], instr_i[25:0], 2'b00};
    else if (w_taken)    next_pc_o = pc_plus4_i + w_br_off;
    else                 next_pc_o = pc_plus4_i;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit : multi-cycle fetch FSM, PC and EPC owner                 |
// | Optional interrupt entry enabled by macro FETCH_INT_EN               |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = C_RESET_PC
`ifdef FETCH_INT_EN
  , parameter logic [31:0] INT_VECTOR = C_INT_VECTOR
`endif
) (
  input  logic        clk,
  input  logic        rst,
  fetch_unit_if.master imem,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  input  logic        branch,
  input  logic        branch_eq,
  input  logic        branch_leq,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic        sys,
  input  logic        exce_ret,
  input  logic        cond_eq,
  input  logic        cond_leq,
  input  logic [31:0] rs_data,
  input  logic        sys_halt,
`ifdef FETCH_INT_EN
  input  logic        int_req,
  output logic        int_ack,
`endif
  output logic        halted
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic [31:0]  epc_q;
  logic [31:0]  w_next_pc;
  logic         w_exec;
  logic         w_halt_req;

  assign w_exec     = (state_q == S_EXEC) && !rst;
  assign w_halt_req = sys && sys_halt;

  assign imem.req    = (state_q == S_FETCH) && !rst;
  assign imem.addr   = pc_q;
  assign instr       = instr_q;
  assign op          = instr_q[31:26];
  assign funct       = instr_q[5:0];
  assign instr_valid = w_exec;
  assign halted      = (state_q == S_HALT) && !rst;
  assign pc_out      = pc_q;
  assign pc_plus4    = pc_q + 32'd4;

`ifdef FETCH_INT_EN
  logic ie_q;
  logic w_take_int;
  assign w_take_int = w_exec && int_req && ie_q && !w_halt_req;
  assign int_ack    = w_take_int;
`endif

  next_pc_sel u_next_pc_sel (
    .branch_i     (branch),
    .branch_eq_i  (branch_eq),
    .branch_leq_i (branch_leq),
    .jump_i       (jump),
    .jump_reg_i   (jump_reg),
    .exce_ret_i   (exce_ret),
    .cond_eq_i    (cond_eq),
    .cond_leq_i   (cond_leq),
    .instr_i      (instr_q),
    .pc_plus4_i   (pc_plus4),
    .rs_data_i    (rs_data),
    .epc_i        (epc_q),
    .next_pc_o    (w_next_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      epc_q   <= RESET_PC;
`ifdef FETCH_INT_EN
      ie_q    <= 1'b1;
`endif
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem.ack) begin
            instr_q <= imem.rdata;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          state_q <= w_halt_req ? S_HALT : S_FETCH;
`ifdef FETCH_INT_EN
          // Interrupt entry wins over a simultaneous eret re-enable.
          if (w_take_int) begin
            epc_q <= w_next_pc;
            pc_q  <= INT_VECTOR;
            ie_q  <= 1'b0;
          end else begin
            pc_q <= w_next_pc;
            if (exce_ret) ie_q <= 1'b1;
          end
`else
          pc_q <= w_next_pc;
`endif
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_unit : self-checking bench with a PC reference model        |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_fetch_unit;
  import mips_pkg::*;

  localparam logic [9:0] F_BR    = 10'h200;
  localparam logic [9:0] F_BEQ   = 10'h100;
  localparam logic [9:0] F_BLEQ  = 10'h080;
  localparam logic [9:0] F_J     = 10'h040;
  localparam logic [9:0] F_JR    = 10'h020;
  localparam logic [9:0] F_SYS   = 10'h010;
  localparam logic [9:0] F_ERET  = 10'h008;
  localparam logic [9:0] F_CEQ   = 10'h004;
  localparam logic [9:0] F_CLEQ  = 10'h002;
  localparam logic [9:0] F_SHALT = 10'h001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] instr, pc_out, pc_plus4, rs_data;
  logic [5:0]  op, funct;
  logic instr_valid, halted;
  logic branch, branch_eq, branch_leq, jump, jump_reg, sys, exce_ret;
  logic cond_eq, cond_leq, sys_halt;
  logic int_req, int_ack;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc, m_epc;
  logic        m_ie;

  fetch_unit_if imem_bus ();

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (imem_bus.master),
    .instr       (instr),
    .op          (op),
    .funct       (funct),
    .instr_valid (instr_valid),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4),
    .branch      (branch),
    .branch_eq   (branch_eq),
    .branch_leq  (branch_leq),
    .jump        (jump),
    .jump_reg    (jump_reg),
    .sys         (sys),
    .exce_ret    (exce_ret),
    .cond_eq     (cond_eq),
    .cond_leq    (cond_leq),
    .rs_data     (rs_data),
    .sys_halt    (sys_halt),
`ifdef FETCH_INT_EN
    .int_req     (int_req),
    .int_ack     (int_ack),
`endif
    .halted      (halted)
  );

`ifndef FETCH_INT_EN
  assign int_ack = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Next PC straight from the architectural rules, in plain arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] w,
                                           input logic [31:0] rs, input logic [31:0] epc,
                                           input logic [9:0] f);
    logic [31:0] p4;
    logic        taken;
    int          imm;
    p4    = pc + 32'd4;
    imm   = int'($signed(w[15:0]));
    taken = ((f & F_BR) != 0) &&
            ((((f & F_BLEQ) != 0) && ((f & F_CLEQ) != 0)) ||
             (((f & F_BEQ) != 0) && ((f & F_CEQ) != 0)) ||
             (((f & F_BEQ) == 0) && ((f & F_BLEQ) == 0) && ((f & F_CEQ) == 0)));
    if ((f & F_ERET) != 0)     return epc;
    else if ((f & F_JR) != 0)  return rs;
    else if ((f & F_J) != 0)   return (p4 & 32'hF000_0000) | (32'(w[25:0]) * 32'd4);
    else if (taken)            return p4 + 32'(imm * 4);
    else                       return p4;
  endfunction

  task automatic set_flags(input logic [9:0] f);
    branch     = f[9];
    branch_eq  = f[8];
    branch_leq = f[7];
    jump       = f[6];
    jump_reg   = f[5];
    sys        = f[4];
    exce_ret   = f[3];
    cond_eq    = f[2];
    cond_leq   = f[1];
    sys_halt   = f[0];
  endtask

  task automatic model_reset();
    m_pc  = C_RESET_PC;
    m_epc = C_RESET_PC;
    m_ie  = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_bus.ack = 1'b0;
    @(negedge clk);
    chk("rst_req", imem_bus.req, 1'b0);
    @(negedge clk);
    chk("rst_req2", imem_bus.req, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_int_ack", int_ack, 1'b0);
    rst = 1'b0;
    model_reset();
  endtask

  // One full instruction: fetch with dly wait cycles, then the EXEC cycle.
  task automatic exec_instr(input logic [31:0] w, input logic [9:0] f,
                            input logic [31:0] rs, input int dly, input logic intr);
    int n;
    logic [31:0] nxt;
    logic        take;
    n = 0;
    while (imem_bus.req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_wait", imem_bus.req, 1'b1);
    for (int d = 0; d <= dly; d++) begin
      chk("fetch_req", imem_bus.req, 1'b1);
      chk("fetch_addr", imem_bus.addr, m_pc);
      imem_bus.ack   = (d == dly);
      imem_bus.rdata = (d == dly) ? w : $urandom;
      @(negedge clk);
    end
    imem_bus.ack   = 1'($urandom_range(0, 1));
    imem_bus.rdata = $urandom;
    set_flags(f);
    rs_data = rs;
    int_req = intr;
    nxt  = ref_next(m_pc, w, rs, m_epc, f);
`ifdef FETCH_INT_EN
    take = intr && m_ie && !(((f & F_SYS) != 0) && ((f & F_SHALT) != 0));
`else
    take = 1'b0;
`endif
    chk("exec_valid", instr_valid, 1'b1);
    chk("exec_req", imem_bus.req, 1'b0);
    chk("exec_instr", instr, w);
    chk("exec_op", 32'(op), 32'(w[31:26]));
    chk("exec_funct", 32'(funct), 32'(w[5:0]));
    chk("exec_pc", pc_out, m_pc);
    chk("exec_pc4", pc_plus4, m_pc + 32'd4);
    chk("exec_int_ack", int_ack, take);
    if (take) begin
      m_epc = nxt;
      m_pc  = C_INT_VECTOR;
      m_ie  = 1'b0;
    end else begin
      m_pc = nxt;
      if ((f & F_ERET) != 0) m_ie = 1'b1;
    end
    @(negedge clk);
    imem_bus.ack = 1'b0;
    set_flags(10'h0);
    int_req = 1'b0;
    chk("post_valid", instr_valid, 1'b0);
  endtask

  initial begin
    logic [31:0] w;
    logic [9:0]  f;
    imem_bus.ack   = 1'b0;
    imem_bus.rdata = 32'h0;
    rs_data = 32'h0;
    int_req = 1'b0;
    set_flags(10'h0);

    do_reset();
    exec_instr(32'h0128_5020, 10'h0, 32'h0, 3, 1'b0);
    exec_instr(32'h0000_0000, 10'h0, 32'h0, 0, 1'b0);
    exec_instr(32'h0000_0000, 10'h0, 32'h0, 1, 1'b0);
    exec_instr(32'h0000_0000, 10'h0, 32'h0, 0, 1'b0);
    w = {C_OP_BEQ, 5'd1, 5'd2, 16'hFFFF};
    exec_instr(w, F_BR | F_BEQ | F_CEQ, 32'h0, 0, 1'b0);
    exec_instr(w, F_BR | F_BEQ, 32'h0, 2, 1'b0);
    exec_instr(32'h03E0_0008, F_JR, 32'h1000_0000, 0, 1'b0);
    exec_instr({C_OP_J, 26'h000_0040}, F_J, 32'h0, 1, 1'b0);
    exec_instr(32'h03E0_0008, F_JR, 32'h0040_0020, 0, 1'b0);
    exec_instr(32'h03E0_0008, F_JR, 32'hFFFF_FFFC, 0, 1'b0);
    exec_instr(32'h0128_5020, 10'h0, 32'h0, 0, 1'b0);
    chk("wrap_pc", imem_bus.addr, 32'h0);

    for (int i = 0; i < 40; i++) begin
      w = $urandom;
      f = 10'($urandom);
      if (f[4]) f[0] = 1'b0;
      exec_instr(w, f, $urandom, int'($urandom_range(0, 3)), 1'b0);
    end

`ifdef FETCH_INT_EN
    exec_instr(32'h03E0_0008, F_JR, 32'h0000_0020, 0, 1'b0);
    exec_instr(32'h0128_5020, 10'h0, 32'h0, 0, 1'b1);
    chk("int_vec", imem_bus.addr, 32'h80);
    exec_instr(32'h0128_5020, 10'h0, 32'h0, 1, 1'b1);
    exec_instr(32'h4200_0018, F_ERET, 32'h0, 0, 1'b0);
    chk("eret_pc", imem_bus.addr, 32'h24);
`endif

    exec_instr(32'h0000_000C, F_SYS | F_SHALT, 32'h0, 1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk("halt_flag", halted, 1'b1);
      chk("halt_req", imem_bus.req, 1'b0);
      @(negedge clk);
    end
    do_reset();
    exec_instr(32'h0128_5020, 10'h0, 32'h0, 0, 1'b0);

    // Reset mid-fetch with an ack arriving during reset.
    repeat (2) @(negedge clk);
    chk("abort_addr", imem_bus.addr, 32'h4);
    rst = 1'b1;
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("abort_req", imem_bus.req, 1'b0);
    rst = 1'b0;
    imem_bus.ack = 1'b0;
    model_reset();
    chk("abort_instr", instr, 32'h0);
    chk("abort_refetch", imem_bus.addr, C_RESET_PC);
    exec_instr(32'h0128_5020, 10'h0, 32'h0, 2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
